// File: rtl/uart_lite_tx.sv
// Transmit-only 8N1 UART serializer with a fixed clocks-per-bit divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_lite_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] message,
    output logic       tx,
    output logic       ready
);

    localparam int              CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST = 3'd7;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    logic [1:0]    r_rst_sync;
    logic          w_run;

    state_t        r_state;
    state_t        w_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift;
    logic          r_tx;
    logic          w_tx;
    logic          r_ready;
    logic          w_ready;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
    logic          w_parity;
`endif

    // Two-flop release of reset: starts are only honoured once the release has propagated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

    // State, counters, shifter and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_tx     <= w_tx;
            r_ready  <= w_ready;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity;
`endif
        end
    end

    // Next-state logic; tx/ready are computed one cycle ahead so the flops line up with the state.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_tx     = r_tx;
        w_ready  = r_ready;
`ifdef UART_TX_PARITY_EN
        w_parity = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                if (start && r_ready && w_run) begin
                    w_state  = S_START;
                    w_cnt    = '0;
                    w_bit    = 3'd0;
                    w_shift  = message;
                    w_tx     = 1'b0;
                    w_ready  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity = ^message;
`endif
                end else begin
                    w_tx    = 1'b1;
                    w_ready = 1'b1;
                end
            end

            S_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_state = S_DATA;
                    w_cnt   = '0;
                    w_tx    = r_shift[0];
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt = '0;
                    if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = r_parity;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        // Next bit is shift[1] now, and shift[0] once the shift lands.
                        w_bit   = r_bit + 3'd1;
                        w_shift = {1'b0, r_shift[7:1]};
                        w_tx    = r_shift[1];
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state = S_STOP;
                    w_cnt   = '0;
                    w_tx    = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
`endif

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_bit   = 3'd0;
                    w_tx    = 1'b1;
                    w_ready = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_bit   = 3'd0;
                w_tx    = 1'b1;
                w_ready = 1'b1;
            end
        endcase
    end

    assign tx    = r_tx;
    assign ready = r_ready;

endmodule

// File: tb/tb_uart_lite_tx.sv
// Randomized self-checking bench for uart_lite_tx against a frame-level bit-list model.
// Honours UART_TX_PARITY_EN to expect the extra parity bit.
module tb_uart_lite_tx;

    localparam int C = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] message;
    logic       tx;
    logic       ready;

    int n_checks = 0;
    int n_fail   = 0;

    uart_lite_tx #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .message (message),
        .tx      (tx),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for bit-time b of a frame carrying m.
    function automatic logic exp_bit(input logic [7:0] m, input int b);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(m[i]);
        if (NB == 11) q.push_back(^m);
        q.push_back(1'b1);
        return q[b];
    endfunction

    // Watches one frame starting at the first negedge after acceptance, then checks ready rises.
    task automatic check_frame(input logic [7:0] m, input bit keep_start,
                               input logic [7:0] next_msg, input int inject_at);
        int   bad_hold = 0;
        int   bad_rdy  = 0;
        int   idx      = 0;
        logic mid      = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < C; k++) begin
                @(negedge clk);
                if (idx == 0) begin
                    start   = keep_start;
                    message = next_msg;
                end else if (idx == inject_at) begin
                    start   = 1'b1;
                    message = 8'h55;
                end else if (idx == inject_at + 1) begin
                    start = 1'b0;
                end else if (!keep_start && (idx % 37 == 0)) begin
                    message = 8'($urandom);
                end
                if (tx !== exp_bit(m, b)) bad_hold++;
                if (ready !== 1'b0) bad_rdy++;
                if (k == C / 2) mid = tx;
                idx++;
            end
            check_eq($sformatf("frame%02h_bit%0d", m, b), 32'(mid), 32'(exp_bit(m, b)));
        end
        check_eq($sformatf("frame%02h_hold", m), 32'(bad_hold), 32'd0);
        check_eq($sformatf("frame%02h_ready_low", m), 32'(bad_rdy), 32'd0);
        @(negedge clk);
        check_eq($sformatf("frame%02h_ready_rise", m), 32'(ready), 32'd1);
        check_eq($sformatf("frame%02h_tx_idle", m), 32'(tx), 32'd1);
    endtask

    task automatic send(input logic [7:0] m);
        @(negedge clk);
        start   = 1'b1;
        message = m;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
        end
        check_eq(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [7:0] m;
        int         gap;
        rst     = 1'b1;
        start   = 1'b0;
        message = 8'h00;

        repeat (5) @(negedge clk);
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        check_idle("idle_after_reset", 1000);

        send(8'hA4);
        check_frame(8'hA4, 1'b0, 8'($urandom), -1);

        send(8'hA4);
        check_frame(8'hA4, 1'b0, 8'($urandom), 5 * C);
        check_idle("busy_no_second_frame", 2 * C);

        send(8'h00);
        check_frame(8'h00, 1'b1, 8'hFF, -1);
        check_frame(8'hFF, 1'b0, 8'($urandom), -1);
        check_idle("b2b_no_third_frame", 20);

        send(8'hC3);
        @(negedge clk);
        start = 1'b0;
        repeat (4 * C + C / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midframe_rst_tx", 32'(tx), 32'd1);
        check_eq("midframe_rst_ready", 32'(ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h3C);
        check_frame(8'h3C, 1'b0, 8'($urandom), -1);

        for (int r = 0; r < 4; r++) begin
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            m = 8'($urandom);
            send(m);
            check_frame(m, 1'b0, 8'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
